// File: rtl/axi_lite_reg_arbiter.sv
// axi_lite_reg_arbiter
//   Two-requester round-robin arbiter in front of an AXI4-Lite master port
//   that talks to a four-register (32-bit) slave. One transaction is in
//   flight at a time.
// Ports
//   ACLK, ARESET              : clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata: requester N command, held until reqN_ready
//   reqN_ready                : single-cycle accept pulse (same cycle as grant)
//   rspN_valid/rdata/resp     : single-cycle completion pulse; data/resp hold
//   M_AXI_*                   : AXI4-Lite master (AW, W, B, AR, R channels)
module axi_lite_reg_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,

  input  logic                      req0_valid,
  input  logic                      req0_write,
  input  logic [C_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [C_DATA_WIDTH-1:0]   req0_wdata,
  output logic                      req0_ready,
  output logic                      rsp0_valid,
  output logic [C_DATA_WIDTH-1:0]   rsp0_rdata,
  output logic [1:0]                rsp0_resp,

  input  logic                      req1_valid,
  input  logic                      req1_write,
  input  logic [C_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [C_DATA_WIDTH-1:0]   req1_wdata,
  output logic                      req1_ready,
  output logic                      rsp1_valid,
  output logic [C_DATA_WIDTH-1:0]   rsp1_rdata,
  output logic [1:0]                rsp1_resp,

  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,

  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,

  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,

  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,

  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t                    state;
  logic                      last_grant;
  logic                      grant_id;
  logic [C_ADDR_WIDTH-1:0]   cmd_addr;
  logic [C_DATA_WIDTH-1:0]   cmd_wdata;

  logic                      grant_any;
  logic                      grant_sel;
  logic                      sel_write;
  logic [C_ADDR_WIDTH-1:0]   sel_addr;
  logic [C_DATA_WIDTH-1:0]   sel_wdata;

  logic                      rsp_fire;
  logic [C_DATA_WIDTH-1:0]   rsp_data;
  logic [1:0]                rsp_code;

  assign M_AXI_AWADDR = cmd_addr;
  assign M_AXI_ARADDR = cmd_addr;
  assign M_AXI_WDATA  = cmd_wdata;
  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_WSTRB  = '1;

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req1_valid;
    end
    sel_write = grant_sel ? req1_write : req0_write;
    sel_addr  = grant_sel ? req1_addr  : req0_addr;
    sel_wdata = grant_sel ? req1_wdata : req0_wdata;
  end

  assign req0_ready = (state == IDLE) && !ARESET && grant_any && !grant_sel;
  assign req1_ready = (state == IDLE) && !ARESET && grant_any &&  grant_sel;

  // Completion source per state. A misaligned command enters RESP without a
  // pulse; RESP then fires the SLVERR pulse one cycle later, so the pulse
  // always comes out of a registered stage.
  always_comb begin
    rsp_fire = 1'b0;
    rsp_data = '0;
    rsp_code = '0;
    case (state)
      WR_RESP: begin
        rsp_fire = M_AXI_BVALID;
        rsp_code = M_AXI_BRESP;
      end
      RD_DATA: begin
        rsp_fire = M_AXI_RVALID;
        rsp_data = M_AXI_RDATA;
        rsp_code = M_AXI_RRESP;
      end
      RESP: begin
        rsp_fire = !(rsp0_valid || rsp1_valid);
        rsp_code = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      cmd_addr      <= '0;
      cmd_wdata     <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            grant_id   <= grant_sel;
            last_grant <= grant_sel;
            cmd_addr   <= sel_addr;
            cmd_wdata  <= sel_wdata;
            if (sel_addr[1:0] != 2'b00) begin
              state <= RESP;
            end else if (sel_write) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
              (!M_AXI_WVALID  || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            state        <= RESP;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp0_valid || rsp1_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-requester response registers: only the granted requester's copy
  // changes, so each side keeps its own last result between pulses.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_resp  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_resp  <= '0;
    end else begin
      rsp0_valid <= rsp_fire && !grant_id;
      rsp1_valid <= rsp_fire &&  grant_id;
      if (rsp_fire && !grant_id) begin
        rsp0_rdata <= rsp_data;
        rsp0_resp  <= rsp_code;
      end
      if (rsp_fire && grant_id) begin
        rsp1_rdata <= rsp_data;
        rsp1_resp  <= rsp_code;
      end
    end
  end

endmodule

// File: doc/axi_lite_reg_arbiter.md
AXI_LITE_REG_ARBITER -- requirements
Module: axi_lite_reg_arbiter

Interface
REQ-001 Parameter C_ADDR_WIDTH, 4, byte address width of the target register block (four 32-bit registers).
REQ-002 Parameter C_DATA_WIDTH, 32, data width; only 32 supported.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: ACLK in 1 rising-edge clock; ARESET in 1 synchronous active-high reset.
REQ-004 reqN_valid / reqN_write / reqN_addr / reqN_wdata (N=0,1) in 1/1/C_ADDR_WIDTH/32: requester N command, write when reqN_write=1, held until accepted.
REQ-005 reqN_ready out 1: one-cycle pulse, command N accepted and captured.
REQ-006 rspN_valid / rspN_rdata / rspN_resp out 1/32/2: one-cycle completion pulse, read data (0 on writes), AXI response code.
REQ-007 M_AXI_AWADDR/AWPROT/AWVALID out C_ADDR_WIDTH/3/1; M_AXI_AWREADY in 1: write address channel.
REQ-008 M_AXI_WDATA/WSTRB/WVALID out 32/4/1; M_AXI_WREADY in 1: write data channel.
REQ-009 M_AXI_BRESP/BVALID in 2/1; M_AXI_BREADY out 1: write response channel.
REQ-010 M_AXI_ARADDR/ARPROT/ARVALID out C_ADDR_WIDTH/3/1; M_AXI_ARREADY in 1: read address channel.
REQ-011 M_AXI_RDATA/RRESP/RVALID in 32/2/1; M_AXI_RREADY out 1: read data channel.

Function
REQ-012 One outstanding AXI4-Lite transaction at a time; AWPROT=ARPROT=3'b000, WSTRB=4'hF constant.
REQ-013 FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RESP.
REQ-014 IDLE: arbitrate among asserted reqN_valid; grant pulses reqN_ready same cycle; write, addr, wdata, grant id captured on that edge.
REQ-015 Arbitration round-robin: both valid -> requester other than last granted wins; single valid -> that one wins; pointer updates only on grant.
REQ-016 Captured addr[1:0]!=0 -> no AXI activity; next state RESP with resp=2'b10 (SLVERR), rdata=0.
REQ-017 Aligned write -> WR next cycle: AWVALID and WVALID both asserted; each deasserts independently after its own handshake; both done -> WR_RESP.
REQ-018 WR_RESP: BREADY=1; on BVALID capture BRESP -> RESP.
REQ-019 Aligned read -> RD_ADDR: ARVALID=1 until ARREADY -> RD_DATA: RREADY=1; on RVALID capture RDATA, RRESP -> RESP.
REQ-020 RESP: rspN_valid=1 for exactly one cycle to granted N only, rdata/resp stable that cycle -> IDLE; no new grant in RESP cycle.
REQ-021 Minimum latency, zero-wait slave: grant T, AW/W valid T+1, BVALID T+2, rspN_valid T+3; reads identical via AR/R.
REQ-022 AW/AR address and WDATA SHALL stay stable while valid and not handshaken; BREADY/RREADY asserted only in their wait states.
REQ-023 reqN_valid dropping after acceptance has no effect on the in-flight transaction.
REQ-024 rspN_rdata/rspN_resp hold last values outside the rsp pulse.

Reset
REQ-025 ARESET=1 at a clock edge: state IDLE, all M_AXI *VALID/*READY=0, reqN_ready=0, rspN_valid=0, rdata/resp/addr/data regs=0, round-robin pointer favours requester 0.
REQ-026 Reset mid-transaction abandons it; no rsp pulse issued for it; arbitration resumes first cycle after ARESET=0.

Verification
REQ-027 Write 0x00000001..0x00000004 from req0 to addr 0x0,0x4,0x8,0xC, then read back from req1 -> rsp1_rdata equals 1,2,3,4 in order, resp 2'b00.
REQ-028 req0 and req1 valid same cycle after reset, continuously -> grants alternate 0,1,0,1; each rsp goes only to its requester.
REQ-029 Slave stalls AWREADY 3 cycles, WREADY 0 cycles -> WVALID drops after 1 cycle, AWVALID held 4 cycles, AWADDR stable; single rsp0_valid pulse.
REQ-030 req0 read addr 0x6 -> no ARVALID ever, rsp0_valid with resp 2'b10, rdata 0, two cycles after grant.
REQ-031 ARESET asserted while in RD_DATA -> next cycle all valids/readies 0, no rsp pulse; subsequent read of 0x4 completes normally.
REQ-032 Zero-wait slave, single write -> rsp0_valid exactly 3 cycles after reqN_ready pulse.
